// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU BIST controller: FSM encoding, opcodes,
// LFSR/MISR polynomials and the LFSR step function.
package alu_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } bist_state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam logic [8:0]  MISR_TAPS         = 9'h011;

    // Fibonacci step for x^16+x^14+x^13+x^11+1: feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shifts left, folds the MSB back through
// the tap mask and XORs in the parallel data word.
module bist_misr
    import alu_bist_pkg::*;
#(
    parameter int           W    = 9,
    parameter logic [W-1:0] TAPS = W'(MISR_TAPS),
    parameter logic [W-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_seed,
    input  logic         enable,
    input  logic [W-1:0] d,
    output logic [W-1:0] sig
);

    logic [W-1:0] r_sig;
    logic [W-1:0] w_next;

    always_comb begin
        w_next = {r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? TAPS : '0) ^ d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= SEED;
        end else if (load_seed) begin
            r_sig <= SEED;
        end else if (enable) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST controller for the 8-bit ALU: LFSR operands, opcode sweep, MISR
// compaction of {ZERO, RESULT} and a final golden-signature compare.
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               PAT_COUNT  = 16,
    parameter logic [15:0]      LFSR_SEED  = 16'hACE1,
    parameter logic [WIDTH:0]   MISR_SEED  = '0,
    parameter logic [WIDTH:0]   GOLDEN_SIG = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_sel,
    output logic               test_mode,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [WIDTH:0]     signature
);

    localparam int          CNT_W    = (PAT_COUNT > 1) ? $clog2(PAT_COUNT) : 1;
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? LFSR_DEFAULT_SEED : LFSR_SEED;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_COUNT - 1);

    bist_state_t      r_state;
    bist_state_t      w_state_nxt;

    logic [15:0]      r_lfsr;
    logic [15:0]      w_lfsr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_sel;
    logic             r_busy;
    logic             r_test_mode;
    logic             r_done;
    logic             r_pass;
    logic             r_match;

    logic             w_launch;
    logic             w_capture;
    logic             w_pat_wrap;
    logic [WIDTH:0]   w_sig;

    assign w_lfsr_nxt = lfsr_next(r_lfsr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort outranks everything; start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        w_pat_wrap  = (r_cnt == CNT_LAST);
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_APPLY;
                    w_launch    = 1'b1;
                end
            end
            ST_APPLY: begin
                w_state_nxt = abort ? ST_IDLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = (w_pat_wrap && (r_alu_sel == OP_NOP)) ? ST_COMPARE : ST_APPLY;
                end
            end
            ST_COMPARE: begin
                w_state_nxt = abort ? ST_IDLE : ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr      <= SEED_EFF;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_busy      <= 1'b0;
            r_test_mode <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_match     <= 1'b0;
        end else begin
            if (w_launch) begin
                r_lfsr      <= SEED_EFF;
                r_alu_a     <= SEED_EFF[15:8];
                r_alu_b     <= SEED_EFF[7:0];
                r_alu_sel   <= OP_ADD;
                r_cnt       <= '0;
                r_busy      <= 1'b1;
                r_test_mode <= 1'b1;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
            end else if (w_capture) begin
                r_lfsr  <= w_lfsr_nxt;
                r_alu_a <= w_lfsr_nxt[15:8];
                r_alu_b <= w_lfsr_nxt[7:0];
                if (w_pat_wrap) begin
                    r_cnt <= '0;
                    // The final opcode is left on the bus so the compare sees a stable ALU.
                    if (r_alu_sel != OP_NOP) begin
                        r_alu_sel <= r_alu_sel + 3'd1;
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if (abort) begin
                r_busy      <= 1'b0;
                r_test_mode <= 1'b0;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
            end else if (r_state == ST_COMPARE) begin
                r_match <= (w_sig == GOLDEN_SIG);
            end else if ((r_state == ST_DONE) && !start) begin
                r_done      <= 1'b1;
                r_pass      <= r_match;
                r_busy      <= 1'b0;
                r_test_mode <= 1'b0;
            end
        end
    end

    bist_misr #(
        .W    (WIDTH + 1),
        .TAPS (MISR_TAPS),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_seed (w_launch),
        .enable    (w_capture),
        .d         ({alu_zero, alu_result}),
        .sig       (w_sig)
    );

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign test_mode = r_test_mode;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = w_sig;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: behavioural ALU with injectable faults, a
// reference signature model and a done-triggered scoreboard.
module tb_alu_bist_ctrl;

    localparam int          PC   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, a} * {8'd0, b};
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (a < b) ? 8'd1 : 8'd0;
            3'd6:    return prod[7:0];
            default: return 8'd0;
        endcase
    endfunction

    // Expected final signature of a whole run; kind 1/2 = RESULT bit stuck-at-0/1, 3 = ZERO stuck-at-1.
    function automatic logic [8:0] ref_sig(input int kind, input int fbit);
        logic [15:0] l;
        logic [8:0]  m;
        logic [8:0]  n;
        logic [7:0]  r;
        logic        z;
        logic [2:0]  fb;
        fb = fbit[2:0];
        l  = SEED;
        m  = 9'h000;
        for (int op = 0; op < 8; op++) begin
            for (int p = 0; p < PC; p++) begin
                r = alu_model(op[2:0], l[15:8], l[7:0]);
                z = (r == 8'd0);
                if (kind == 1) r[fb] = 1'b0;
                else if (kind == 2) r[fb] = 1'b1;
                else if (kind == 3) z = 1'b1;
                n    = {m[7:0], m[8]} ^ {z, r};
                n[4] = n[4] ^ m[8];
                m    = n;
                l    = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            end
        end
        return m;
    endfunction

    localparam logic [8:0] GOLD = ref_sig(0, 0);

    typedef struct {
        logic [8:0] sig;
        logic       pass;
        int         cyc_done;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic       test_mode;
    logic [7:0] w_res;
    logic       w_zero;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] signature;

    logic [1:0] f_kind;
    logic [2:0] f_bit;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    alu_bist_ctrl #(
        .WIDTH      (8),
        .PAT_COUNT  (PC),
        .LFSR_SEED  (SEED),
        .MISR_SEED  (9'h000),
        .GOLDEN_SIG (GOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .test_mode  (test_mode),
        .alu_result (w_res),
        .alu_zero   (w_zero),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        w_res  = alu_model(alu_sel, alu_a, alu_b);
        w_zero = (w_res == 8'd0);
        case (f_kind)
            2'd1:    w_res[f_bit] = 1'b0;
            2'd2:    w_res[f_bit] = 1'b1;
            2'd3:    w_zero = 1'b1;
            default: ;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising edge of done retires one expectation.
    initial begin
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_q = 1'b0;
            end else begin
                if (done && !done_q) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("done_cycle", cyc, e.cyc_done);
                        check("final_signature", int'(signature), int'(e.sig));
                        check("final_pass", int'(pass), int'(e.pass));
                        check("busy_at_done", int'(busy), 0);
                        check("test_mode_at_done", int'(test_mode), 0);
                    end
                end
                done_q = done;
            end
        end
    end

    // Leaves the bench at the falling edge right after the start-sampling edge (edge 0).
    task automatic start_run(input logic [1:0] k, input logic [2:0] b, input bit expect_done);
        exp_t ex;
        int   t0;
        f_kind = k;
        f_bit  = b;
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        if (expect_done) begin
            ex.sig      = ref_sig(int'(k), int'(b));
            ex.pass     = (ex.sig == GOLD);
            ex.cyc_done = t0 + 1 + 258;
            sb.push_back(ex);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sb(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic abort_at(input int edge_n);
        logic [8:0] sig_h;
        logic [7:0] a_h;
        logic [7:0] b_h;
        start_run(2'd0, 3'd0, 1'b0);
        repeat (edge_n - 1) @(negedge clk);
        abort = 1'b1;
        sig_h = signature;
        a_h   = alu_a;
        b_h   = alu_b;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_test_mode", int'(test_mode), 0);
        check("abort_sig_held", int'(signature), int'(sig_h));
        check("abort_a_held", int'(alu_a), int'(a_h));
        check("abort_b_held", int'(alu_b), int'(b_h));
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        f_kind = 2'd0;
        f_bit  = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_a", int'(alu_a), 0);
        check("rst_b", int'(alu_b), 0);
        check("rst_sel", int'(alu_sel), 0);
        check("rst_test_mode", int'(test_mode), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_signature", int'(signature), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean run with first-pattern and opcode-step checks
        start_run(2'd0, 3'd0, 1'b1);
        check("p1_sel", int'(alu_sel), 0);
        check("p1_a", int'(alu_a), 'hAC);
        check("p1_b", int'(alu_b), 'hE1);
        check("p1_busy", int'(busy), 1);
        check("p1_test_mode", int'(test_mode), 1);
        repeat (2) @(negedge clk);
        check("p2_a", int'(alu_a), 'h59);
        check("p2_b", int'(alu_b), 'hC3);
        repeat (28) @(negedge clk);
        check("sel_before_wrap", int'(alu_sel), 0);
        repeat (2) @(negedge clk);
        check("sel_after_wrap", int'(alu_sel), 1);
        wait_sb(400);
        repeat (5) @(negedge clk);
        check("done_held", int'(done), 1);
        check("pass_held", int'(pass), 1);
        check("sig_frozen", int'(signature), int'(GOLD));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_done_done", int'(done), 0);
        check("abort_in_done_pass", int'(pass), 0);
        check("abort_in_done_sig", int'(signature), int'(GOLD));

        // Fault runs: RESULT[0] stuck-at-0, ZERO stuck-at-1, then a random stuck bit
        start_run(2'd1, 3'd0, 1'b1);
        wait_sb(400);
        start_run(2'd3, 3'd0, 1'b1);
        wait_sb(400);
        start_run(2'($urandom_range(1, 2)), 3'($urandom_range(0, 7)), 1'b1);
        wait_sb(400);

        // Abort at edge 50, then a clean run must match the golden signature
        abort_at(50);
        start_run(2'd0, 3'd0, 1'b1);
        wait_sb(400);
        for (int i = 0; i < 2; i++) begin
            abort_at(int'($urandom_range(2, 255)));
            start_run(2'd0, 3'd0, 1'b1);
            wait_sb(400);
        end

        // Start re-pulsed while busy is ignored
        start_run(2'd0, 3'd0, 1'b1);
        repeat (19) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sb(400);

        // Abort and start together from DONE: abort wins
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", int'(busy), 0);
        check("abort_start_done", int'(done), 0);

        // Asynchronous reset mid-run
        start_run(2'd0, 3'd0, 1'b0);
        repeat (99) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_test_mode", int'(test_mode), 0);
        check("async_rst_sig", int'(signature), 0);
        check("async_rst_a", int'(alu_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
- Built-in self-test controller for the 8-bit ALU (ports A, B, SEL in; RESULT, ZERO out). It drives the ALU's inputs and consumes its outputs.
- Generates pseudo-random operand pairs with an LFSR and sweeps all eight opcodes (ADD, SUB, AND, OR, XOR, CMP, MUL, NOP).
- Compacts {ZERO, RESULT} into a MISR and compares the final signature against a golden value.
- Sits beside the ALU. A test-mode mux, outside this block, selects between functional operands and this block's outputs.

Parameters:
- WIDTH, 8, ALU operand/result width.
- PAT_COUNT, 16, operand patterns applied per opcode (must be ≥1).
- LFSR_SEED, 16'hACE1, LFSR start value. A value of 0 is replaced by 16'hACE1.
- MISR_SEED, 9'h000, MISR start value.
- GOLDEN_SIG, 9'h000, expected final signature.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; begins a run when idle or done.
- abort, input, 1, synchronous; cancels a run.
- alu_a, output, WIDTH, ALU operand A (registered).
- alu_b, output, WIDTH, ALU operand B (registered).
- alu_sel, output, 3, ALU opcode (registered).
- test_mode, output, 1, high while the controller owns the ALU inputs.
- alu_result, input, WIDTH, ALU RESULT.
- alu_zero, input, 1, ALU ZERO.
- busy, output, 1, run in progress.
- done, output, 1, run complete; held until next start/abort/reset.
- pass, output, 1, signature match; valid when done=1.
- signature, output, WIDTH+1, current MISR contents.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - alu_a=0, alu_b=0, alu_sel=0.
  - test_mode=0, busy=0, done=0, pass=0.
  - signature=MISR_SEED, LFSR=LFSR_SEED, pattern counter=0.
- Reset mid-run aborts immediately with the same values.
- FSM states: IDLE, APPLY, CAPTURE, COMPARE, DONE.
- IDLE/DONE with start=1 at edge 0:
  - LFSR reloads seed; MISR reloads MISR_SEED.
  - alu_sel=0, done=0, pass=0, busy=1, test_mode=1.
  - alu_a=seed[15:8], alu_b=seed[7:0].
  - Next state APPLY.
- APPLY: ALU inputs held stable one cycle for combinational settling. Next state is always CAPTURE.
- CAPTURE:
  - MISR absorbs d={alu_zero, alu_result}.
  - LFSR advances; alu_a/alu_b load the new LFSR[15:8]/[7:0].
  - Pattern counter increments.
  - When the counter wraps at PAT_COUNT-1: counter=0 and alu_sel increments.
  - After the last pattern of SEL=7: next state COMPARE, without changing alu_sel. Otherwise next state APPLY.
- LFSR:
  - 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
  - next = {l[14:0], l[15]^l[13]^l[12]^l[10]}.
  - Runs continuously across opcodes; not reseeded per opcode.
- MISR (9-bit, x^9+x^4+1):
  - n[0]=m[8]^d[0].
  - n[4]=m[3]^m[8]^d[4].
  - n[i]=m[i-1]^d[i] otherwise.
- COMPARE: pass <= (MISR==GOLDEN_SIG). Next state DONE.
- DONE entry: done=1, busy=0, test_mode=0.
- Timing with default parameters:
  - Run = 8*PAT_COUNT patterns × 2 cycles = 256 cycles (edges 1..256).
  - COMPARE at edge 257.
  - done and pass rise at edge 258.
- Boundary and priority rules:
  - start while busy: ignored.
  - abort while busy: next edge state=IDLE, busy=0, done=0, pass=0, test_mode=0. Operand registers are held; the MISR is left as-is.
  - abort and start in the same cycle: abort wins.
  - abort in IDLE/DONE: clears done/pass and goes to IDLE.
  - signature is visible at all times and is frozen in DONE.

Decomposition:
- Package alu_bist_pkg holds:
  - state encoding.
  - opcode constants OP_ADD..OP_NOP (3'b000..3'b111).
  - LFSR tap mask 16'hB400 and default seed 16'hACE1.
  - MISR tap mask 9'h011.
- One sub-module, bist_misr:
  - parameterised width/taps.
  - inputs clk, rst_n, load_seed, enable, d.
  - output sig.
- The LFSR stays inline.

Test Plan:
- Reset applied -> all outputs 0, signature=9'h000. Assert rst_n low mid-run (edge 100) -> busy=0 and test_mode=0 immediately (asynchronous).
- start pulse -> pattern 1 on ALU: SEL=0, A=8'hAC, B=8'hE1. After the first capture: A=8'h59, B=8'hC3. SEL increments to 1 after 16 captures.
- Full run against a behavioural ALU, with GOLDEN_SIG set from the bench reference model -> done=1 at edge 258, busy=0, pass=1, signature==GOLDEN_SIG.
- Same run with RESULT bit 0 stuck-at-0 (and separately ZERO stuck-at-1) -> done=1 at edge 258, pass=0, signature≠GOLDEN_SIG.
- abort at edge 50 -> IDLE at edge 51, busy=0, done=0. A subsequent start reproduces the identical signature of a clean run.
- start re-pulsed at edge 20 while busy -> no effect; done still at edge 258 with an identical signature.
